// File: rtl/oflow_registration_pipe_ctrl_if.sv
// Handshake bundle between the core controller, the registration sequencer
// and the score-calc / score-board engines.
interface oflow_registration_pipe_ctrl_if #(
  parameter int PE_W    = 5,
  parameter int SET_W   = 6,
  parameter int ID_W    = 12,
  parameter int FRAME_W = 16
);
  logic [FRAME_W-1:0] frame_num;
  logic [SET_W-1:0]   num_of_sets;
  logic               start_registration;
  logic               abort;
  logic [PE_W-1:0]    num_of_pe;
  logic               done_score_calc;
  logic               start_score_calc;
  logic [SET_W-1:0]   row_sel_calc;
  logic               done_score_board;
  logic               start_score_board;
  logic [SET_W-1:0]   row_sel_board;
  logic [ID_W-1:0]    id_first_frame;
  logic               busy;
  logic               done_registration;
  logic               proto_err;

  // Sequencer side
  modport master (
    input  frame_num, num_of_sets, start_registration, abort, num_of_pe,
           done_score_calc, done_score_board,
    output start_score_calc, row_sel_calc, start_score_board, row_sel_board,
           id_first_frame, busy, done_registration, proto_err
  );

  // Core controller / engine side
  modport slave (
    output frame_num, num_of_sets, start_registration, abort, num_of_pe,
           done_score_calc, done_score_board,
    input  start_score_calc, row_sel_calc, start_score_board, row_sel_board,
           id_first_frame, busy, done_registration, proto_err
  );
endinterface

// File: rtl/oflow_registration_pipe_ctrl.sv
// Registration sequencer: overlaps score-calc of set k+1 with score-board of
// set k, with a board-only first-frame mode that generates PE IDs.
//
// state  | meaning
// IDLE   | waiting for start_registration
// RUN    | issuing calc/board starts until all N sets are board-complete
// FINISH | one cycle; schedules the done_registration pulse
module oflow_registration_pipe_ctrl #(
  parameter int PE_NUM  = 24,
  parameter int PE_W    = 5,
  parameter int SET_W   = 6,
  parameter int ID_W    = 12,
  parameter int FRAME_W = 16,
  parameter int AHEAD   = 2
) (
  input  logic clk,
  input  logic reset_N,
  oflow_registration_pipe_ctrl_if.master bus
);
  localparam int CW = SET_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   n_q, n_d;
  logic            first_q, first_d;
  logic [CW-1:0]   calc_iss_q, calc_iss_d, calc_done_q, calc_done_d;
  logic [CW-1:0]   board_iss_q, board_iss_d, board_done_q, board_done_d;
  logic            start_calc_q, start_board_q;
  logic [SET_W-1:0] row_calc_q, row_board_q;
  logic            busy_q, busy_d;
  logic            done_q, err_q, id_vld_q;
  logic            calc_busy, board_busy, err_ev, calc_go, board_go;
  logic [ID_W-1:0] id_calc;

  // _d counters are the post-done values of this cycle; issue decisions use them
  always_comb begin
    calc_busy    = calc_iss_q > calc_done_q;
    board_busy   = board_iss_q > board_done_q;
    err_ev       = (bus.done_score_calc && !calc_busy)
                || (bus.done_score_board && !board_busy)
                || (bus.start_registration && busy_q)
                || (bus.done_score_calc && first_q && busy_q);
    state_d      = state_q;
    n_d          = n_q;
    first_d      = first_q;
    calc_iss_d   = calc_iss_q;
    board_iss_d  = board_iss_q;
    calc_done_d  = calc_done_q + CW'(bus.done_score_calc && calc_busy);
    board_done_d = board_done_q + CW'(bus.done_score_board && board_busy);
    case (state_q)
      IDLE: begin
        if (bus.start_registration) begin
          n_d          = {1'b0, bus.num_of_sets};
          first_d      = (bus.frame_num == '0);
          calc_iss_d   = '0;
          calc_done_d  = '0;
          board_iss_d  = '0;
          board_done_d = '0;
          state_d      = (bus.num_of_sets != '0) ? RUN : FINISH;
        end
      end
      RUN:     if (board_done_d == n_q) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    calc_go  = (state_d == RUN) && !first_d
            && (calc_iss_d <= calc_done_d)
            && (calc_iss_d < n_d)
            && ((calc_iss_d - board_done_d) < CW'(AHEAD));
    board_go = (state_d == RUN)
            && (board_iss_d <= board_done_d)
            && (first_d ? (board_iss_d < n_d) : (board_iss_d < calc_done_d));
    busy_d   = (state_d == RUN) || ((state_d == FINISH) && busy_q);
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q       <= IDLE;
      n_q           <= '0;
      first_q       <= 1'b0;
      calc_iss_q    <= '0;
      calc_done_q   <= '0;
      board_iss_q   <= '0;
      board_done_q  <= '0;
      start_calc_q  <= 1'b0;
      start_board_q <= 1'b0;
      row_calc_q    <= '0;
      row_board_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      id_vld_q      <= 1'b0;
    end else if (bus.abort) begin
      state_q       <= IDLE;
      calc_iss_q    <= '0;
      calc_done_q   <= '0;
      board_iss_q   <= '0;
      board_done_q  <= '0;
      start_calc_q  <= 1'b0;
      start_board_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      id_vld_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      first_q       <= first_d;
      calc_done_q   <= calc_done_d;
      board_done_q  <= board_done_d;
      calc_iss_q    <= calc_iss_d + CW'(calc_go);
      board_iss_q   <= board_iss_d + CW'(board_go);
      start_calc_q  <= calc_go;
      start_board_q <= board_go;
      if (calc_go)  row_calc_q  <= calc_iss_d[SET_W-1:0];
      if (board_go) row_board_q <= board_iss_d[SET_W-1:0];
      busy_q        <= busy_d;
      done_q        <= (state_q == FINISH);
      err_q         <= err_q | err_ev;
      id_vld_q      <= id_vld_q | board_go;
    end
  end

  // ID stays zero until the first board start so that reset drives all outputs low
  assign id_calc = ID_W'(row_board_q) * ID_W'(PE_NUM) + ID_W'(bus.num_of_pe) + ID_W'(1);

  assign bus.start_score_calc  = start_calc_q;
  assign bus.row_sel_calc      = row_calc_q;
  assign bus.start_score_board = start_board_q;
  assign bus.row_sel_board     = row_board_q;
  assign bus.id_first_frame    = id_vld_q ? id_calc : '0;
  assign bus.busy              = busy_q;
  assign bus.done_registration = done_q;
  assign bus.proto_err         = err_q;
endmodule

// File: doc/oflow_registration_pipe_ctrl.md
Name: oflow_registration_pipe_ctrl

Overview:
- Parametrised successor of the registration sequencer.
- Drives the score-calc and score-board engines over `num_of_sets` sets for one frame.
- Overlaps the two engines: score-calc of set k+1 runs while score-board consumes set k.
- Adds a first-frame bypass with ID generation, a completion pulse, protocol-error flagging and a synchronous abort. Sits between the core controller and the score-calc / score-board blocks.

Parameters:
- PE_NUM, 24, number of PEs per set; multiplier for first-frame IDs.
- PE_W, 5, width of num_of_pe.
- SET_W, 6, width of set counters and num_of_sets.
- ID_W, 12, width of id_first_frame.
- FRAME_W, 16, width of frame_num.
- AHEAD, 2, max sets started to calc but not yet completed by board; legal range 1..3.

Ports:
- clk  in  1  clock
- reset_N  in  1  asynchronous active-low reset
- frame_num  in  FRAME_W  current frame index; 0 selects first-frame mode
- num_of_sets  in  SET_W  sets this frame; sampled on start_registration
- start_registration  in  1  one-cycle start pulse
- abort  in  1  synchronous clear; returns the block to IDLE
- num_of_pe  in  PE_W  PE index used for the first-frame ID
- done_score_calc  in  1  one-cycle completion from score-calc
- start_score_calc  out  1  one-cycle start to score-calc
- row_sel_calc  out  SET_W  set index for the current or last calc start
- done_score_board  in  1  one-cycle completion from score-board
- start_score_board  out  1  one-cycle start to score-board
- row_sel_board  out  SET_W  set index for the current or last board start
- id_first_frame  out  ID_W  row_sel_board*PE_NUM + num_of_pe + 1
- busy  out  1  high from the cycle after an accepted start until done_registration
- done_registration  out  1  one-cycle completion pulse
- proto_err  out  1  sticky error flag; cleared by abort or reset

Behaviour:
- Reset (async, reset_N=0): all outputs 0; counters 0; state IDLE. Takes effect mid-operation with no pending pulses.
- States: IDLE, RUN, FINISH.
- IDLE → RUN on start_registration when num_of_sets≠0.
  - Latch num_of_sets as N.
  - Latch mode = (frame_num==0) as FIRST.
- IDLE → FINISH on start_registration when num_of_sets==0.
- RUN → FINISH when board_done==N.
- FINISH → IDLE after 1 cycle; done_registration=1 in that cycle.
- Counters (SET_W+1 bits, no wrap since ≤N): calc_iss, calc_done, board_iss, board_done.
- Calc busy = calc_iss > calc_done. Board busy = board_iss > board_done.
- Normal mode, calc issue: registered start_score_calc pulses when all hold:
  - state RUN;
  - calc not busy;
  - calc_iss < N;
  - calc_iss − board_done < AHEAD.
  - On that cycle: row_sel_calc ← calc_iss, then calc_iss increments.
- Normal mode, board issue: start_score_board pulses when all hold:
  - state RUN;
  - board not busy;
  - board_iss < calc_done.
  - On that cycle: row_sel_board ← board_iss, then board_iss increments.
- FIRST mode:
  - Never issues calc.
  - Board issue condition is board_iss < N with board not busy.
  - id_first_frame is valid while start_score_board is high and holds until the next board start.
- Latencies:
  - start_registration at cycle 0 → first start pulse at cycle 1.
  - done_X at cycle t is counted at t; a dependent start can fire at t+1.
  - Final done_score_board at t → done_registration at t+2 (RUN→FINISH at t+1).
- Simultaneous events:
  - done_score_calc and done_score_board in the same cycle are both counted.
  - An issue decision uses the counter values after that cycle's increments.
- id arithmetic: computed in ID_W bits, truncating on overflow; combinational from registered row_sel_board.
- proto_err is set on any of:
  - done_score_calc while calc is not busy;
  - done_score_board while board is not busy;
  - start_registration while busy;
  - done_score_calc in FIRST mode.
- start_registration while busy is ignored and does not relaunch.
- abort: on the next edge, state IDLE, counters 0, busy 0, proto_err 0, no done_registration. Takes priority over every other event, including a simultaneous start_registration.
- The block does not change latched N or mode during RUN; frame_num changes during RUN are ignored.

Test Plan:
- First frame: frame_num=0, N=3, PE_NUM=24, num_of_pe=5. Each done_score_board returns 4 cycles after its start.
  - Expected: three board starts with id_first_frame=6, 30, 54.
  - No start_score_calc; done_registration 2 cycles after the 3rd done; busy drops with it.
- Overlap: frame_num=7, N=4, AHEAD=2, calc takes 3 cycles, board takes 10.
  - Calc of set 1 starts the cycle after calc 0 is done.
  - Calc of set 2 waits until done_score_board for set 0.
  - row_sel sequences are 0,1,2,3 on both engines.
- Zero sets: start_registration with num_of_sets=0 → done_registration at cycle 2; no engine starts; busy stays 0.
- Same-cycle dones: done_score_calc(set 1) and done_score_board(set 0) in one cycle → start_score_board for set 1 at the next cycle; proto_err stays 0.
- Protocol errors:
  - Spurious done_score_board in IDLE → proto_err=1.
  - Then abort → proto_err=0.
  - start_registration during RUN → ignored; proto_err=1.
- Abort and reset mid-run:
  - abort during set 2 of N=5 → IDLE next cycle, no done_registration; a subsequent start with N=2 completes normally.
  - reset_N low mid-run → all outputs 0 asynchronously.
